control_multiciclo: RTL



---
 rtl/cu_pkg.sv | 71 +++++++
 rtl/alu_param.sv | 62 ++++++
 rtl/control_multiciclo.sv | 138 +++++++++++++
 3 files changed

// File: rtl/cu_pkg.sv
// Shared encodings, FSM states and the instruction layout for the multi-cycle control unit.
package cu_pkg;

  // Instruction classes, held in bits [7:6]
  localparam logic [1:0] CLS_LDI = 2'b00;
  localparam logic [1:0] CLS_MOV = 2'b01;
  localparam logic [1:0] CLS_ALU = 2'b10;
  localparam logic [1:0] CLS_CTL = 2'b11;

  // ALU operation codes, held in bits [2:0] of an ALU-class instruction
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_NOT = 3'd5;
  localparam logic [2:0] ALU_SHL = 3'd6;
  localparam logic [2:0] ALU_SHR = 3'd7;

  // Sub-class selector, held in bits [5:3] of an ALU-class instruction
  localparam logic [2:0] SUB_ALU = 3'b000;
  localparam logic [2:0] SUB_IN  = 3'b110;
  localparam logic [2:0] SUB_OUT = 3'b111;

  // Complete control-class encodings
  localparam logic [7:0] ENC_JC0  = 8'hC0;
  localparam logic [7:0] ENC_JC1  = 8'hC1;
  localparam logic [7:0] ENC_JMP  = 8'hC2;
  localparam logic [7:0] ENC_HALT = 8'hFF;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_EXEC    = 2'd1,
    ST_WAIT_IN = 2'd2,
    ST_HALT    = 2'd3
  } state_t;

  typedef struct packed {
    logic [1:0] cls;
    logic [2:0] a;
    logic [2:0] b;
  } instr_t;

  // One-hot style decode of the latched instruction
  typedef struct packed {
    logic ldi;
    logic mov;
    logic alu;
    logic in;
    logic out;
    logic jc;
    logic jmp;
    logic halt;
  } dec_t;

  // Classify an instruction; anything not matched is a NOP
  function automatic dec_t decode(input instr_t ir);
    dec_t d;
    d      = '0;
    d.ldi  = (ir.cls == CLS_LDI);
    d.mov  = (ir.cls == CLS_MOV);
    d.alu  = (ir.cls == CLS_ALU) && (ir.a == SUB_ALU);
    d.in   = (ir.cls == CLS_ALU) && (ir.a == SUB_IN);
    d.out  = (ir.cls == CLS_ALU) && (ir.a == SUB_OUT);
    d.jc   = (ir[7:1] == ENC_JC0[7:1]);
    d.jmp  = (ir == ENC_JMP);
    d.halt = (ir == ENC_HALT);
    return d;
  endfunction

endpackage

// File: rtl/alu_param.sv
// Combinational ALU: R3 result and the condition flag for the eight ALU operations.
module alu_param
  import cu_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        op,
  output logic [DATA_W-1:0] result,
  output logic              flag_out
);

  logic [DATA_W:0] sum;

  // Result and flag per opcode; logic ops report a zero result on the flag
  always_comb begin
    sum      = '0;
    result   = '0;
    flag_out = 1'b0;
    case (op)
      ALU_ADD: begin
        sum      = {1'b0, a} + {1'b0, b};
        result   = sum[DATA_W-1:0];
        flag_out = sum[DATA_W];
      end
      ALU_SUB: begin
        result   = a - b;
        flag_out = (a < b);
      end
      ALU_AND: begin
        result   = a & b;
        flag_out = (result == '0);
      end
      ALU_OR: begin
        result   = a | b;
        flag_out = (result == '0);
      end
      ALU_XOR: begin
        result   = a ^ b;
        flag_out = (result == '0);
      end
      ALU_NOT: begin
        result   = ~a;
        flag_out = (result == '0);
      end
      ALU_SHL: begin
        result   = {a[DATA_W-2:0], 1'b0};
        flag_out = a[DATA_W-1];
      end
      ALU_SHR: begin
        result   = {1'b0, a[DATA_W-1:1]};
        flag_out = a[0];
      end
      default: begin
        result   = '0;
        flag_out = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/control_multiciclo.sv
// Multi-cycle control unit: fetch over req/ack, decode, execute on R0..R7 and the ALU.
module control_multiciclo
  import cu_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned PC_W   = 8
) (
  input  logic              clck,
  input  logic              rst,
  output logic [PC_W-1:0]   imem_addr,
  output logic              imem_req,
  input  logic              imem_ack,
  input  logic [7:0]        imem_data,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] salida,
  output logic              out_valid,
  output logic              flag,
  output logic              halted
);

  localparam int unsigned NREGS = 8;

  state_t            state;
  instr_t            ir;
  logic [PC_W-1:0]   pc;
  logic [DATA_W-1:0] regs [NREGS];

  dec_t              dec;
  logic              jump_taken;
  logic [DATA_W-1:0] alu_res;
  logic              alu_flag;

  assign imem_addr = pc;

  // Decode of the latched instruction and the branch decision
  always_comb begin
    dec        = decode(ir);
    jump_taken = dec.jmp || (dec.jc && (flag == ir.b[0]));
  end

  // Operands are fixed: R1 op R2, opcode in the low field
  alu_param #(
    .DATA_W (DATA_W)
  ) u_alu (
    .a        (regs[1]),
    .b        (regs[2]),
    .op       (ir.b),
    .result   (alu_res),
    .flag_out (alu_flag)
  );

  // Control FSM with register file, PC, flag and all outputs registered
  always_ff @(posedge clck or posedge rst) begin
    if (rst) begin
      state     <= ST_FETCH;
      ir        <= '0;
      pc        <= '0;
      flag      <= 1'b0;
      salida    <= '0;
      out_valid <= 1'b0;
      imem_req  <= 1'b0;
      in_ready  <= 1'b0;
      halted    <= 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      case (state)
        ST_FETCH: begin
          // Request is raised on the first cycle out of reset; an ack only counts while req is up
          if (!imem_req) begin
            imem_req <= 1'b1;
          end else if (imem_ack) begin
            ir       <= instr_t'(imem_data);
            pc       <= pc + PC_W'(1);
            imem_req <= 1'b0;
            state    <= ST_EXEC;
          end
        end

        ST_EXEC: begin
          state    <= ST_FETCH;
          imem_req <= 1'b1;
          if (dec.ldi) begin
            regs[0] <= DATA_W'({ir.a, ir.b});
          end
          if (dec.mov) begin
            regs[ir.a] <= regs[ir.b];
          end
          if (dec.alu) begin
            regs[3] <= alu_res;
            flag    <= alu_flag;
          end
          if (dec.out) begin
            salida    <= regs[ir.b];
            out_valid <= 1'b1;
          end
          // Overrides the PC already incremented during fetch
          if (jump_taken) begin
            pc <= PC_W'(regs[0]);
          end
          if (dec.in) begin
            state    <= ST_WAIT_IN;
            imem_req <= 1'b0;
            in_ready <= 1'b1;
          end
          if (dec.halt) begin
            state    <= ST_HALT;
            imem_req <= 1'b0;
            halted   <= 1'b1;
          end
        end

        ST_WAIT_IN: begin
          // Data is taken only here; in_valid elsewhere is dropped
          if (in_valid) begin
            regs[ir.b] <= in_data;
            in_ready   <= 1'b0;
            imem_req   <= 1'b1;
            state      <= ST_FETCH;
          end
        end

        ST_HALT: begin
          state <= ST_HALT;
        end

        default: begin
          state <= ST_FETCH;
        end
      endcase
    end
  end

endmodule
